button_conditioner: RTL and testbench
=====================================

# button_conditioner

Front-end conditioning stage for the pedal's three navigation buttons, sitting directly upstream of the `control` block. It synchronises the raw, bouncing push-button inputs to the system clock and debounces them, then produces the clean levels that drive `control.butn_in`. It also generates per-button press pulses, long-press detection and auto-repeat pulses for menu navigation. Bit mapping everywhere: bit0 = right, bit1 = center, bit2 = left.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 240000: consecutive stable synchronised cycles required to accept a level change (20 ms at 12 MHz); legal range ≥ 2.
- HOLD_CYCLES, 6000000: cycles a debounced press must persist before a long-press is flagged (0.5 s); must exceed DEBOUNCE_CYCLES.
- REPEAT_CYCLES, 1500000: auto-repeat period once held (125 ms); legal range ≥ 2.
- REPEAT_MASK, 3'b101: buttons that auto-repeat (right and left; center does not).

Ports:
- clk, input, 1: system clock; the single clock of the block.
- rst_n, input, 1: asynchronous, active-low reset.
- butn_raw, input, 3: raw button pins, active-high, asynchronous to clk, bouncing.
- butn_out, output, 3: debounced levels; connect to `control.butn_in`.
- butn_press, output, 3: one-cycle pulse on each accepted press (debounced rising edge).
- butn_release, output, 3: one-cycle pulse on each accepted release.
- butn_hold, output, 3: high while a press has lasted ≥ HOLD_CYCLES; low otherwise.
- butn_repeat, output, 3: one-cycle auto-repeat pulses for REPEAT_MASK buttons while held.

## Operation
- Three identical, fully independent channels. Simultaneous presses, releases or holds on different buttons never interact.
- Synchroniser: two flops per bit (sync1, sync2), both reset to 0.
- Debounce counter per bit, width $clog2(DEBOUNCE_CYCLES):
  - When sync2 == butn_out, the counter is cleared.
  - When sync2 != butn_out, the counter increments.
  - At the edge where sync2 != butn_out and the counter == DEBOUNCE_CYCLES-1, butn_out toggles and the counter clears.
  - Any bounce back to the current level restarts the count from 0.
- Per-channel FSM with states IDLE, PRESSED and HELD:
  - IDLE → PRESSED on butn_out rising. butn_press pulses and the hold counter clears.
  - PRESSED → HELD when the hold counter reaches HOLD_CYCLES-1 with butn_out still high. butn_hold rises and the repeat counter clears.
  - HELD: if the bit is set in REPEAT_MASK, butn_repeat pulses each time the repeat counter reaches REPEAT_CYCLES-1; the counter then wraps to 0.
  - PRESSED or HELD → IDLE on butn_out falling. butn_release pulses, butn_hold drops in the same cycle, and the hold and repeat counters clear.
- Hold and repeat counters saturate/wrap only as described; no overflow is possible given the widths.
- Reset values: every output, synchroniser flop and counter is 0; every FSM is in IDLE.
- Reset asserted mid-press: all state clears immediately, with no release pulse. If butn_raw is still high after rst_n deasserts, it is accepted as a fresh press after the full synchronise-plus-debounce latency.

## Timing
- Let N be the first rising edge that samples a new stable butn_raw value. butn_out changes at edge N+1+DEBOUNCE_CYCLES, and butn_press or butn_release is high for the cycle following that edge.
- butn_hold rises exactly HOLD_CYCLES edges after the edge where butn_out rose.
- Repeat pulses follow the edge where butn_hold rose by k·REPEAT_CYCLES edges, k = 1, 2, … The first pulse is not coincident with hold entry.
- butn_press, butn_release and butn_repeat are never high for two consecutive cycles. butn_press and butn_release are never high in the same cycle.
- Downstream `control` samples butn_out on its slow clock. Any accepted press is guaranteed to remain ≥ DEBOUNCE_CYCLES long, and `control` is responsible for edge detection on its side.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8.
- Reset: hold rst_n=0 with butn_raw=3'b111 → all outputs 0. Release reset → butn_out becomes 3'b111 at edge 6 after the first sample, and butn_press=3'b111 pulses once.
- Bounce rejection: drive butn_raw[0] with the pattern 1,0,1,1,0 followed by steady 1 → exactly one butn_press[0] pulse. butn_out[0] rises 5 edges after the steady-1 run begins.
- Glitch: a 3-cycle-wide high pulse on butn_raw[2] → butn_out, butn_press and butn_release all stay 0.
- Long press with repeat: hold butn_raw[0]=1 → butn_hold[0] rises 20 edges after butn_out[0] rose, then butn_repeat[0] pulses every 8 cycles. Releasing gives exactly one butn_release[0] pulse, and butn_hold[0] falls with butn_out[0].
- Masked channel: hold butn_raw[1]=1 for 60 cycles → butn_hold[1]=1 and butn_repeat[1] is never asserted.
- Simultaneous and mid-operation reset: press right and left together, then pulse rst_n low while in HELD → both channels show identical timing, and reset clears butn_hold/butn_out with no butn_release pulse.

Source files
------------

// File: rtl/button_conditioner.sv
// Three-channel push-button front end: two-flop synchroniser, debounce, and a
// per-button press/hold/auto-repeat FSM feeding control.butn_in.
module button_conditioner #(
    parameter int         DEBOUNCE_CYCLES = 240000,
    parameter int         HOLD_CYCLES     = 6000000,
    parameter int         REPEAT_CYCLES   = 1500000,
    parameter logic [2:0] REPEAT_MASK     = 3'b101
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] butn_raw,
    output logic [2:0] butn_out,
    output logic [2:0] butn_press,
    output logic [2:0] butn_release,
    output logic [2:0] butn_hold,
    output logic [2:0] butn_repeat
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(HOLD_CYCLES);
    localparam int REP_W  = $clog2(REPEAT_CYCLES);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } state_t;

    for (genvar i = 0; i < 3; i++) begin : g_chan
        logic              sync1;
        logic              sync2;
        logic [DB_W-1:0]   db_cnt;
        logic              level;
        logic              db_flip;
        logic              rise;
        logic              fall;

        state_t            state;
        state_t            state_next;
        logic [HOLD_W-1:0] hold_cnt;
        logic [HOLD_W-1:0] hold_cnt_next;
        logic [REP_W-1:0]  rep_cnt;
        logic [REP_W-1:0]  rep_cnt_next;
        logic              press_q;
        logic              press_next;
        logic              release_q;
        logic              release_next;
        logic              repeat_q;
        logic              repeat_next;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1 <= 1'b0;
                sync2 <= 1'b0;
            end else begin
                sync1 <= butn_raw[i];
                sync2 <= sync1;
            end
        end

        // The level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
        assign db_flip = (sync2 != level) && (db_cnt == DB_LAST);
        assign rise    = db_flip && !level;
        assign fall    = db_flip && level;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                db_cnt <= '0;
                level  <= 1'b0;
            end else begin
                if (sync2 == level || db_flip) begin
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
                if (db_flip) begin
                    level <= ~level;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state     <= IDLE;
                hold_cnt  <= '0;
                rep_cnt   <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                repeat_q  <= 1'b0;
            end else begin
                state     <= state_next;
                hold_cnt  <= hold_cnt_next;
                rep_cnt   <= rep_cnt_next;
                press_q   <= press_next;
                release_q <= release_next;
                repeat_q  <= repeat_next;
            end
        end

        // Pulses are registered so they line up with the debounced level change.
        always_comb begin
            state_next    = state;
            hold_cnt_next = hold_cnt;
            rep_cnt_next  = rep_cnt;
            press_next    = 1'b0;
            release_next  = 1'b0;
            repeat_next   = 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state_next    = PRESSED;
                        press_next    = 1'b1;
                        hold_cnt_next = '0;
                    end
                end
                PRESSED: begin
                    if (fall) begin
                        state_next    = IDLE;
                        release_next  = 1'b1;
                        hold_cnt_next = '0;
                        rep_cnt_next  = '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state_next   = HELD;
                        rep_cnt_next = '0;
                    end else begin
                        hold_cnt_next = hold_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (fall) begin
                        state_next    = IDLE;
                        release_next  = 1'b1;
                        hold_cnt_next = '0;
                        rep_cnt_next  = '0;
                    end else if (rep_cnt == REP_LAST) begin
                        rep_cnt_next = '0;
                        repeat_next  = REPEAT_MASK[i];
                    end else begin
                        rep_cnt_next = rep_cnt + 1'b1;
                    end
                end
                default: begin
                    state_next    = IDLE;
                    hold_cnt_next = '0;
                    rep_cnt_next  = '0;
                end
            endcase
        end

        assign butn_out[i]     = level;
        assign butn_press[i]   = press_q;
        assign butn_release[i] = release_q;
        assign butn_hold[i]    = (state == HELD);
        assign butn_repeat[i]  = repeat_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with short debounce/hold/repeat times and a
// sample-window reference model of the button behaviour.
module tb_button_conditioner;

    localparam int         D    = 4;
    localparam int         H    = 20;
    localparam int         R    = 8;
    localparam logic [2:0] MASK = 3'b101;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] butn_raw;
    logic [2:0] butn_out;
    logic [2:0] butn_press;
    logic [2:0] butn_release;
    logic [2:0] butn_hold;
    logic [2:0] butn_repeat;

    int checks = 0;
    int errors = 0;

    button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H),
        .REPEAT_CYCLES  (R),
        .REPEAT_MASK    (MASK)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .butn_raw    (butn_raw),
        .butn_out    (butn_out),
        .butn_press  (butn_press),
        .butn_release(butn_release),
        .butn_hold   (butn_hold),
        .butn_repeat (butn_repeat)
    );

    always #5 clk = ~clk;

    // Reference model: a button level flips once the D samples that have made it
    // through the two-edge synchroniser all disagree with it; hold and repeat are
    // derived from the number of edges since the level rose.
    logic [D+1:0] m_hist [3];
    int           m_age  [3];
    logic [2:0]   m_out, m_press, m_rel, m_hold, m_rep;

    logic [D+1:0] nx_hist [3];
    int           nx_age  [3];
    logic [2:0]   nx_flip, nx_out, nx_press, nx_rel, nx_hold, nx_rep;

    always_comb begin
        nx_flip  = '0;
        nx_out   = '0;
        nx_press = '0;
        nx_rel   = '0;
        nx_hold  = '0;
        nx_rep   = '0;
        for (int c = 0; c < 3; c++) begin
            nx_hist[c]  = {m_hist[c][D:0], butn_raw[c]};
            nx_flip[c]  = (nx_hist[c][D+1:2] == {D{~m_out[c]}});
            nx_out[c]   = m_out[c] ^ nx_flip[c];
            nx_press[c] = nx_flip[c] & ~m_out[c];
            nx_rel[c]   = nx_flip[c] & m_out[c];
            nx_age[c]   = nx_press[c] ? 0 : m_age[c] + 1;
            nx_hold[c]  = nx_out[c] && (nx_age[c] >= H);
            nx_rep[c]   = MASK[c] && nx_out[c] && (nx_age[c] > H) && ((nx_age[c] - H) % R == 0);
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 3; c++) begin
                m_hist[c] <= '0;
                m_age[c]  <= 0;
            end
            m_out   <= '0;
            m_press <= '0;
            m_rel   <= '0;
            m_hold  <= '0;
            m_rep   <= '0;
        end else begin
            for (int c = 0; c < 3; c++) begin
                m_hist[c] <= nx_hist[c];
                m_age[c]  <= nx_age[c];
            end
            m_out   <= nx_out;
            m_press <= nx_press;
            m_rel   <= nx_rel;
            m_hold  <= nx_hold;
            m_rep   <= nx_rep;
        end
    end

    logic [14:0] dut_v, exp_v;
    assign dut_v = {butn_out, butn_press, butn_release, butn_hold, butn_repeat};
    assign exp_v = {m_out, m_press, m_rel, m_hold, m_rep};

    task automatic apply_reset();
        rst_n    = 1'b0;
        butn_raw = 3'b000;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int rise_k;
        int press_cnt;
        rst_n    = 1'b0;
        butn_raw = 3'b111;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (dut_v !== 15'h0000) begin
                errors++;
                $display("FAIL reset_outputs got %h expected 0000", dut_v);
            end
        end
        rst_n     = 1'b1;
        rise_k    = -1;
        press_cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            checks++;
            if (dut_v !== exp_v) begin
                errors++;
                $display("FAIL reset_model k=%0d got %h expected %h", k, dut_v, exp_v);
            end
            if (butn_out == 3'b111 && rise_k < 0) rise_k = k;
            if (butn_press == 3'b111) press_cnt++;
        end
        checks++;
        if (rise_k !== 6) begin
            errors++;
            $display("FAIL reset_rise_edge got %0d expected 6", rise_k);
        end
        checks++;
        if (press_cnt !== 1) begin
            errors++;
            $display("FAIL reset_press_count got %0d expected 1", press_cnt);
        end
    endtask

    task automatic test_bounce();
        logic [4:0] pat;
        int rise_k;
        int press_cnt;
        apply_reset();
        pat       = 5'b01101;
        press_cnt = 0;
        rise_k    = -1;
        for (int i = 0; i < 5; i++) begin
            butn_raw[0] = pat[i];
            @(negedge clk);
            checks++;
            if (dut_v !== exp_v) begin
                errors++;
                $display("FAIL bounce_model i=%0d got %h expected %h", i, dut_v, exp_v);
            end
            if (butn_press[0]) press_cnt++;
        end
        butn_raw[0] = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            checks++;
            if (dut_v !== exp_v) begin
                errors++;
                $display("FAIL bounce_model k=%0d got %h expected %h", k, dut_v, exp_v);
            end
            if (butn_press[0]) press_cnt++;
            if (butn_out[0] && rise_k < 0) rise_k = k;
        end
        checks++;
        if (press_cnt !== 1) begin
            errors++;
            $display("FAIL bounce_press_count got %0d expected 1", press_cnt);
        end
        checks++;
        if (rise_k !== 6) begin
            errors++;
            $display("FAIL bounce_rise_edge got %0d expected 6", rise_k);
        end
    endtask

    task automatic test_glitch();
        logic [2:0] seen;
        apply_reset();
        seen = '0;
        for (int k = 0; k < 24; k++) begin
            butn_raw[2] = (k < 3);
            @(negedge clk);
            checks++;
            if (dut_v !== exp_v) begin
                errors++;
                $display("FAIL glitch_model k=%0d got %h expected %h", k, dut_v, exp_v);
            end
            seen = seen | {butn_out[2], butn_press[2], butn_release[2]};
        end
        checks++;
        if (seen !== 3'b000) begin
            errors++;
            $display("FAIL glitch_outputs got %b expected 000", seen);
        end
    endtask

    task automatic test_long_press();
        int rise_k, hold_k, nrep, fall_k, hold_fall_k, rel_cnt;
        int rep_k [2];
        apply_reset();
        rise_k = -1;
        hold_k = -1;
        nrep   = 0;
        rep_k  = '{-1, -1};
        butn_raw[0] = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            checks++;
            if (dut_v !== exp_v) begin
                errors++;
                $display("FAIL long_model k=%0d got %h expected %h", k, dut_v, exp_v);
            end
            if (butn_out[0] && rise_k < 0) rise_k = k;
            if (butn_hold[0] && hold_k < 0) hold_k = k;
            if (butn_repeat[0]) begin
                if (nrep < 2) rep_k[nrep] = k;
                nrep++;
            end
        end
        checks++;
        if (rise_k !== 6 || hold_k - rise_k !== H) begin
            errors++;
            $display("FAIL long_hold_delay got rise=%0d hold=%0d expected rise=6 hold=26", rise_k, hold_k);
        end
        checks++;
        if (rep_k[0] - hold_k !== R || rep_k[1] - rep_k[0] !== R) begin
            errors++;
            $display("FAIL long_repeat_spacing got %0d,%0d expected %0d,%0d", rep_k[0], rep_k[1], hold_k + R, hold_k + 2 * R);
        end
        checks++;
        if (nrep !== 4) begin
            errors++;
            $display("FAIL long_repeat_count got %0d expected 4", nrep);
        end
        butn_raw[0] = 1'b0;
        fall_k      = -1;
        hold_fall_k = -1;
        rel_cnt     = 0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            checks++;
            if (dut_v !== exp_v) begin
                errors++;
                $display("FAIL long_release_model k=%0d got %h expected %h", k, dut_v, exp_v);
            end
            if (!butn_out[0] && fall_k < 0) fall_k = k;
            if (!butn_hold[0] && hold_fall_k < 0) hold_fall_k = k;
            if (butn_release[0]) rel_cnt++;
        end
        checks++;
        if (rel_cnt !== 1) begin
            errors++;
            $display("FAIL long_release_count got %0d expected 1", rel_cnt);
        end
        checks++;
        if (fall_k !== 6 || hold_fall_k !== fall_k) begin
            errors++;
            $display("FAIL long_hold_fall got out=%0d hold=%0d expected both 6", fall_k, hold_fall_k);
        end
    endtask

    task automatic test_masked();
        logic rep_seen;
        apply_reset();
        rep_seen    = 1'b0;
        butn_raw[1] = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            checks++;
            if (dut_v !== exp_v) begin
                errors++;
                $display("FAIL masked_model k=%0d got %h expected %h", k, dut_v, exp_v);
            end
            rep_seen = rep_seen | butn_repeat[1];
        end
        checks++;
        if (butn_hold[1] !== 1'b1) begin
            errors++;
            $display("FAIL masked_hold got %b expected 1", butn_hold[1]);
        end
        checks++;
        if (rep_seen !== 1'b0) begin
            errors++;
            $display("FAIL masked_repeat got %b expected 0", rep_seen);
        end
    endtask

    task automatic test_simul_reset();
        int rel_cnt;
        int rise_k;
        apply_reset();
        butn_raw = 3'b101;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            checks++;
            if (dut_v !== exp_v) begin
                errors++;
                $display("FAIL simul_model k=%0d got %h expected %h", k, dut_v, exp_v);
            end
            checks++;
            if ({butn_out[0], butn_press[0], butn_hold[0], butn_repeat[0]} !==
                {butn_out[2], butn_press[2], butn_hold[2], butn_repeat[2]}) begin
                errors++;
                $display("FAIL simul_match k=%0d got right=%b%b%b%b left=%b%b%b%b", k,
                         butn_out[0], butn_press[0], butn_hold[0], butn_repeat[0],
                         butn_out[2], butn_press[2], butn_hold[2], butn_repeat[2]);
            end
        end
        checks++;
        if (butn_hold !== 3'b101) begin
            errors++;
            $display("FAIL simul_held got %b expected 101", butn_hold);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dut_v !== 15'h0000) begin
            errors++;
            $display("FAIL simul_async_clear got %h expected 0000", dut_v);
        end
        rel_cnt = 0;
        repeat (2) begin
            @(negedge clk);
            if (butn_release != 3'b000) rel_cnt++;
        end
        rst_n  = 1'b1;
        rise_k = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            checks++;
            if (dut_v !== exp_v) begin
                errors++;
                $display("FAIL simul_after_model k=%0d got %h expected %h", k, dut_v, exp_v);
            end
            if (butn_release != 3'b000) rel_cnt++;
            if (butn_out == 3'b101 && rise_k < 0) rise_k = k;
        end
        checks++;
        if (rel_cnt !== 0) begin
            errors++;
            $display("FAIL simul_no_release got %0d expected 0", rel_cnt);
        end
        checks++;
        if (rise_k !== 6) begin
            errors++;
            $display("FAIL simul_repress_edge got %0d expected 6", rise_k);
        end
    endtask

    task automatic test_random();
        int run_left [3];
        apply_reset();
        run_left = '{0, 0, 0};
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < 3; c++) begin
                if (run_left[c] == 0) begin
                    butn_raw[c] = ~butn_raw[c];
                    run_left[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 60)
                                                              : $urandom_range(1, 6);
                end
                run_left[c]--;
            end
            if (i == 1500) begin
                #3 rst_n = 1'b0;
            end
            @(negedge clk);
            rst_n = 1'b1;
            checks++;
            if (dut_v !== exp_v) begin
                errors++;
                $display("FAIL random_model i=%0d got %h expected %h", i, dut_v, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_glitch();
        test_long_press();
        test_masked();
        test_simul_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
